mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
Job sequencer for a pipelined multiply-accumulate datapath. Accepts a dot-product job with length len, then streams len operand pairs in over a valid/ready handshake. It clears and enables an internal 2-stage MAC, drains the pipeline after the last pair, and presents the ACC_W-bit sum with a sticky overflow flag on a valid/ready result port. It sits between an operand producer (DMA/FIFO) and the result consumer; full-width products are kept, with no truncation.

Parameters:
DATA_W, 32, operand width (unsigned)
ACC_W, 64, accumulator/result width; must be >= 2*DATA_W
LEN_W, 16, width of job length field

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  job request; sampled only in IDLE
len  input  LEN_W  number of operand pairs; sampled with start
abort  input  1  cancel current job; no result produced
busy  output  1  high in any state other than IDLE
a_data  input  DATA_W  operand A
b_data  input  DATA_W  operand B
op_valid  input  1  operand pair valid
op_ready  output  1  high only in RUN
res_data  output  ACC_W  accumulated result
res_ovf  output  1  sticky: carry out of ACC_W occurred during the job
res_valid  output  1  result valid; high only in DONE
res_ready  input  1  consumer accepts result

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, beat counter=0, product reg=0, accumulator=0, drain counter=0. All outputs 0. Takes effect from any state, including mid-RUN and DRAIN; in-flight data is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 with len>0 -> clear accumulator, product reg, and ovf; cnt=len; go to RUN. start=1 with len=0 -> clear accumulator and ovf, go directly to DONE (res_data=0). start is ignored in all other states.
- RUN: op_ready=1. A beat is op_valid&op_ready.
  - On each beat: product reg <= a_data*b_data (2*DATA_W bits, zero-extended to ACC_W); cnt decrements.
  - The beat that takes cnt from 1 to 0 moves to DRAIN.
  - op_valid gaps are allowed. A bubble flows through the pipe as a zero product or held-off enable; it must not double-count.
- MAC pipe: stage 1 registers the product. Stage 2 computes acc <= acc + product when the stage-1 valid bit is set. Addition wraps modulo 2^ACC_W; carry out sets ovf (sticky until next job start).
- DRAIN: op_ready=0. Lasts exactly 2 cycles so the last product is accumulated. If the last beat is sampled at edge E: acc is final after edge E+1, and DONE is entered at edge E+2.
- DONE: res_valid=1. res_data=acc and res_ovf=ovf, held stable while res_ready=0. res_valid&res_ready -> IDLE at that edge. res_data keeps its value in IDLE until the next start.
- abort=1 in RUN/DRAIN/DONE -> IDLE next edge. res_valid drops, the pipe valid bits clear, and no result is handed over. abort has priority over beat, drain completion, and result handshake in the same cycle. abort in IDLE has no effect.
- Simultaneous start+abort in IDLE: start wins.

Decomposition:
- Package mac_pkg: state enum (IDLE, RUN, DRAIN, DONE), default width constants DATA_W/ACC_W/LEN_W, and drain depth constant MAC_PIPE_DEPTH=2.
- One sub-module, mac_pipe:
  - Inputs: clk, reset_n, clr, in_valid, a, b.
  - Outputs: acc, ovf.
  - Contains the 2-stage multiply/accumulate.
- mac_seq_ctrl holds the FSM, counters, and handshakes.

Test Plan:
1. len=3, pairs (1,4),(2,5),(3,6) on consecutive cycles, res_ready=1 -> res_data=32, res_ovf=0. res_valid high 2 edges after the last beat's edge, for 1 cycle; busy returns to 0.
2. start with len=0 -> DONE on the next edge, res_data=0, res_valid=1, op_ready never asserted.
3. Same job as test 1 with op_valid low for 2 cycles between every beat, and res_ready low for 5 cycles -> res_data=32, stable for all 5 cycles. A start pulse during that window is ignored.
4. len=2, A=B=32'hFFFF_FFFF both beats -> res_data=64'hFFFF_FFFC_0000_0002, res_ovf=1. Next job len=1 (2,3) -> res_data=6, res_ovf=0.
5. len=4, abort after 1 beat of (5,5) -> IDLE, no res_valid. New job len=1 (7,9) -> res_data=63 (no stale 25).
6. reset_n=0 for 1 cycle during DRAIN -> next cycle busy=0, op_ready=0, res_valid=0. New job len=1 (3,3) -> res_data=9.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC job sequencer.
package mac_pkg;

    localparam int DATA_W         = 32;
    localparam int ACC_W          = 64;
    localparam int LEN_W          = 16;
    // Cycles between the last accepted operand pair and a final accumulator.
    localparam int MAC_PIPE_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream and result handshake bundle for the MAC job sequencer.
// The master side is the operand producer plus the result consumer.
interface mac_seq_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
);

    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              op_valid;
    logic              op_ready;
    logic [ACC_W-1:0]  res_data;
    logic              res_ovf;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output a_data, b_data, op_valid, res_ready,
        input  op_ready, res_data, res_ovf, res_valid
    );

    modport slave (
        input  a_data, b_data, op_valid, res_ready,
        output op_ready, res_data, res_ovf, res_valid
    );

endinterface

// File: rtl/mac_pipe.sv
// Two-stage multiply/accumulate: stage 1 registers the full-width product,
// stage 2 adds it into the accumulator and records any carry out as sticky overflow.
module mac_pipe #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic [2*DATA_W-1:0] prod_q;
    logic                prod_valid_q;
    logic [ACC_W:0]      sum_ext;

    // Widen both terms by one bit so the carry out of the accumulator is visible.
    always_comb begin
        sum_ext = {1'b0, acc} + (ACC_W + 1)'(prod_q);
    end

    // Stage 1: capture the product and a valid bit so bubbles never accumulate.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
        end else begin
            prod_valid_q <= in_valid;
            if (in_valid) begin
                prod_q <= a * b;
            end
        end
    end

    // Stage 2: accumulate modulo 2^ACC_W; overflow stays set until the next clear.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (prod_valid_q) begin
            acc <= sum_ext[ACC_W-1:0];
            ovf <= ovf | sum_ext[ACC_W];
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: takes a job length, streams that many operand
// pairs into the MAC pipe, waits for the pipe to drain, then offers the sum.
module mac_seq_ctrl #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    mac_seq_ctrl_if.slave    bus
);

    import mac_pkg::*;

    localparam int DRAIN_W = (MAC_PIPE_DEPTH > 1) ? $clog2(MAC_PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MAC_PIPE_DEPTH - 1);

    state_t             state;
    logic [LEN_W-1:0]   cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               op_ready_q;
    logic               res_valid_q;
    logic               beat;
    logic               job_start;
    logic               job_abort;
    logic               pipe_clr;
    logic [ACC_W-1:0]   acc;
    logic               ovf;

    // Handshake qualifiers; abort only counts outside IDLE and clears the pipe.
    always_comb begin
        beat      = bus.op_valid && op_ready_q;
        job_start = (state == IDLE) && start;
        job_abort = (state != IDLE) && abort;
        pipe_clr  = job_start || job_abort;
    end

    // Job FSM with registered busy/op_ready/res_valid; abort outranks everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (job_abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            cnt        <= len;
                            op_ready_q <= 1'b1;
                            state      <= RUN;
                        end else begin
                            res_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            op_ready_q <= 1'b0;
                            drain_cnt  <= DRAIN_LOAD;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mac_pipe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (pipe_clr),
        .in_valid (beat),
        .a        (bus.a_data),
        .b        (bus.b_data),
        .acc      (acc),
        .ovf      (ovf)
    );

    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = acc;
    assign bus.res_ovf   = ovf;

endmodule
